// File: rtl/qmem_pkg.sv
// Shared types and constants for the QMEM slave RAM.
// Holds the FSM state encoding, default bus widths and LFSR constants.
package qmem_pkg;

    localparam int QMEM_QAW = 32;
    localparam int QMEM_QDW = 32;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } qmem_state_e;

    // Fibonacci taps 8,6,5,4 map to state bits 7,5,4,3
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic lfsr_fb(input logic [7:0] s);
        return ^(s & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/qmem_ram_be.sv
// Single-port RAM with per-byte write enables and a registered read port.
// Kept standalone so a vendor macro can replace it.
module qmem_ram_be #(
    parameter int MAW = 10,
    parameter int QDW = 32,
    parameter int QSW = QDW / 8
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_en,
    input  logic           i_we,
    input  logic [QSW-1:0] i_be,
    input  logic [MAW-1:0] i_addr,
    input  logic [QDW-1:0] i_wdata,
    output logic [QDW-1:0] o_rdata
);

    logic [QDW-1:0] r_mem [2**MAW];
    logic [QDW-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_en && i_we) begin
            for (int b = 0; b < QSW; b++) begin
                if (i_be[b]) begin
                    r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Only the read register is reset; the array keeps its contents
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else if (i_en && !i_we) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/qmem_slave_ram.sv
// QMEM slave terminating the bus in a byte-enabled RAM with wait states.
// Define QMEM_SLAVE_RANDOM_DLY_EN to add 0-3 LFSR-driven extra wait states.
module qmem_slave_ram
    import qmem_pkg::*;
#(
    parameter int QAW          = QMEM_QAW,
    parameter int QDW          = QMEM_QDW,
    parameter int QSW          = QDW / 8,
    parameter int MAW          = 10,
    parameter int DLYW         = 4,
    parameter bit PROTO_STICKY = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cs,
    input  logic            we,
    input  logic [QSW-1:0]  sel,
    input  logic [QAW-1:0]  adr,
    input  logic [QDW-1:0]  dat_w,
    output logic [QDW-1:0]  dat_r,
    output logic            ack,
    output logic            err,
    input  logic [DLYW-1:0] dly,
    output logic            proto_err
);

    localparam int BW = $clog2(QSW);

    qmem_state_e     r_state;
    logic            r_we;
    logic [QSW-1:0]  r_sel;
    logic [MAW-1:0]  r_word;
    logic            r_ok;
    logic [QDW-1:0]  r_dat;
    logic [DLYW-1:0] r_cnt;
    logic            r_ack;
    logic            r_err;
    logic            r_proto;

    logic            w_idle;
    logic            w_in_ok;
    logic            w_ok;
    logic            w_we;
    logic [QSW-1:0]  w_sel;
    logic [QSW-1:0]  w_be;
    logic [MAW-1:0]  w_word;
    logic [QDW-1:0]  w_dat;
    logic [DLYW-1:0] w_dly;
    logic            w_enter;
    logic            w_abort;
    logic            w_ram_en;
    logic            w_unused;

`ifdef QMEM_SLAVE_RANDOM_DLY_EN
    logic [7:0]      r_lfsr;
    logic [DLYW:0]   w_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[6:0], lfsr_fb(r_lfsr)};
        end
    end

    assign w_sum = {1'b0, dly} + (DLYW+1)'(r_lfsr[1:0]);
    assign w_dly = w_sum[DLYW] ? '1 : w_sum[DLYW-1:0];
`else
    assign w_dly = dly;
`endif

    assign w_unused = ^adr[BW-1:0];
    assign w_idle   = (r_state == IDLE);
    assign w_in_ok  = (|sel) && (adr[QAW-1:MAW+BW] == '0);

    // Zero-wait requests complete on the accepting edge, so use live inputs
    assign w_we   = w_idle ? we      : r_we;
    assign w_sel  = w_idle ? sel     : r_sel;
    assign w_word = w_idle ? adr[MAW+BW-1:BW] : r_word;
    assign w_dat  = w_idle ? dat_w   : r_dat;
    assign w_ok   = w_idle ? w_in_ok : r_ok;

    assign w_enter = (w_idle && cs && (w_dly == '0))
                   || ((r_state == WAIT) && cs && (r_cnt == DLYW'(1)));
    assign w_abort  = (r_state == WAIT) && !cs;
    assign w_ram_en = w_enter && w_ok && !rst;
    assign w_be     = w_we ? w_sel : '0;

    qmem_ram_be #(
        .MAW (MAW),
        .QDW (QDW),
        .QSW (QSW)
    ) u_ram (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_en    (w_ram_en),
        .i_we    (w_we),
        .i_be    (w_be),
        .i_addr  (w_word),
        .i_wdata (w_dat),
        .o_rdata (dat_r)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_proto <= 1'b0;
        end else begin
            r_ack <= w_enter && w_ok;
            r_err <= w_enter && !w_ok;
            if (w_abort) begin
                r_proto <= 1'b1;
            end else if (!PROTO_STICKY) begin
                r_proto <= 1'b0;
            end
            unique case (r_state)
                IDLE: begin
                    if (cs) begin
                        r_we    <= we;
                        r_sel   <= sel;
                        r_word  <= adr[MAW+BW-1:BW];
                        r_ok    <= w_in_ok;
                        r_dat   <= dat_w;
                        r_cnt   <= w_dly;
                        r_state <= (w_dly == '0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (!cs) begin
                        r_state <= IDLE;
                    end else if (r_cnt == DLYW'(1)) begin
                        r_state <= RESP;
                    end else begin
                        r_cnt <= r_cnt - DLYW'(1);
                    end
                end
                RESP: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ack       = r_ack;
    assign err       = r_err;
    assign proto_err = r_proto;

endmodule

// File: tb/tb_qmem_slave_ram.sv
// Directed bench for qmem_slave_ram: vector table plus abort/reset sequences.
// Drives on the falling edge and samples 1 time unit after the rising edge.
module tb_qmem_slave_ram;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic        ack;
    logic        err;
    logic [3:0]  dly;
    logic        proto_err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  dly;
        logic        hold;
        logic        exp_ack;
        logic        exp_err;
        logic [31:0] exp_dat;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    qmem_slave_ram dut (
        .clk       (clk),
        .rst       (rst),
        .cs        (cs),
        .we        (we),
        .sel       (sel),
        .adr       (adr),
        .dat_w     (dat_w),
        .dat_r     (dat_r),
        .ack       (ack),
        .err       (err),
        .dly       (dly),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic w, input logic [3:0] s,
                                input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] dl, input logic h,
                                input logic ea, input logic ee,
                                input logic [31:0] ed);
        vec_t v;
        v.we = w; v.sel = s; v.adr = a; v.dat = d; v.dly = dl;
        v.hold = h; v.exp_ack = ea; v.exp_err = ee; v.exp_dat = ed;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One transfer; cs held until a response or the cycle budget runs out
    task automatic xfer(input vec_t v, input string nm);
        int lat;
        bit got;
        logic ra;
        logic re;
        logic [31:0] rd;
        @(negedge clk);
        cs = 1'b1; we = v.we; sel = v.sel; adr = v.adr;
        dat_w = v.dat; dly = v.dly;
        lat = 0; got = 1'b0; ra = 1'b0; re = 1'b0; rd = '0;
        while (!got && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (ack || err) begin
                got = 1'b1; ra = ack; re = err; rd = dat_r;
            end else if (lat == 1) begin
                // Latched copies must be used while waiting
                we = ~v.we; sel = 4'h0; adr = 32'hFFFF_FFF0; dat_w = ~v.dat;
            end
        end
        if (v.hold) begin
            @(posedge clk); #1;
            cs = 1'b0;
        end else begin
            cs = 1'b0;
            @(posedge clk); #1;
        end
        chk({nm, " latency"}, lat, 32'(v.dly) + 32'd1);
        chk({nm, " ack/err"}, {30'd0, ra, re}, {30'd0, v.exp_ack, v.exp_err});
        chk({nm, " dat_r"}, rd, v.exp_dat);
        chk({nm, " single pulse"}, {30'd0, ack, err}, 32'd0);
    endtask

    task automatic watch_quiet(input int n, output bit seen);
        seen = 1'b0;
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            if (ack || err) seen = 1'b1;
        end
    endtask

    initial begin
        bit seen;
        rst = 1'b1; cs = 1'b0; we = 1'b0; sel = '0;
        adr = '0; dat_w = '0; dly = '0;

        vecs[0]  = mk(1, 4'hF, 32'h10,        32'hDEADBEEF, 0, 0, 1, 0, 32'h0);
        vecs[1]  = mk(0, 4'hF, 32'h10,        32'h0,        0, 0, 1, 0, 32'hDEADBEEF);
        vecs[2]  = mk(1, 4'hF, 32'h20,        32'h11223344, 0, 0, 1, 0, 32'hDEADBEEF);
        vecs[3]  = mk(1, 4'h2, 32'h20,        32'hAABBCCDD, 0, 0, 1, 0, 32'hDEADBEEF);
        vecs[4]  = mk(0, 4'hF, 32'h20,        32'h0,        0, 0, 1, 0, 32'h1122CC44);
        vecs[5]  = mk(0, 4'h1, 32'h10,        32'h0,        2, 0, 1, 0, 32'hDEADBEEF);
        vecs[6]  = mk(1, 4'hF, 32'h0,         32'hCAFEF00D, 1, 0, 1, 0, 32'hDEADBEEF);
        vecs[7]  = mk(1, 4'hF, 32'h1000,      32'h55555555, 0, 0, 0, 1, 32'hDEADBEEF);
        vecs[8]  = mk(0, 4'hF, 32'h1000,      32'h0,        0, 0, 0, 1, 32'hDEADBEEF);
        vecs[9]  = mk(1, 4'h0, 32'h10,        32'h66666666, 2, 0, 0, 1, 32'hDEADBEEF);
        vecs[10] = mk(0, 4'hF, 32'h10,        32'h0,        5, 1, 1, 0, 32'hDEADBEEF);
        vecs[11] = mk(0, 4'hF, 32'h0,         32'h0,        0, 0, 1, 0, 32'hCAFEF00D);
        vecs[12] = mk(1, 4'hF, 32'hFFC,       32'h0F0E0D0C, 3, 0, 1, 0, 32'hCAFEF00D);
        vecs[13] = mk(0, 4'hF, 32'hFFC,       32'h0,        1, 0, 1, 0, 32'h0F0E0D0C);
        vecs[14] = mk(0, 4'hF, 32'h2000_0000, 32'h0,        1, 0, 0, 1, 32'h0F0E0D0C);

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset outputs", {28'd0, ack, err, proto_err, 1'b0}, 32'd0);
        chk("reset dat_r", dat_r, 32'd0);

        for (int i = 0; i < NV; i++) begin
            xfer(vecs[i], $sformatf("v%0d", i));
        end

        // Abort in WAIT: cs dropped with two wait cycles still pending
        xfer(mk(1, 4'hF, 32'h30, 32'h0BADF00D, 0, 0, 1, 0, 32'h0F0E0D0C), "pre abort");
        @(negedge clk);
        cs = 1'b1; we = 1'b1; sel = 4'hF; adr = 32'h30;
        dat_w = 32'h12345678; dly = 4'd4;
        repeat (3) @(posedge clk);
        @(negedge clk);
        cs = 1'b0;
        watch_quiet(8, seen);
        chk("abort no response", {31'd0, seen}, 32'd0);
        chk("abort proto_err", {31'd0, proto_err}, 32'd1);
        xfer(mk(0, 4'hF, 32'h30, 32'h0, 0, 0, 1, 0, 32'h0BADF00D), "post abort");
        chk("proto_err sticky", {31'd0, proto_err}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst clears proto_err", {31'd0, proto_err}, 32'd0);
        chk("rst clears dat_r", dat_r, 32'd0);

        // Reset in the middle of a waited write
        xfer(mk(1, 4'hF, 32'h40, 32'h77777777, 0, 0, 1, 0, 32'h0), "pre rst");
        @(negedge clk);
        cs = 1'b1; we = 1'b1; sel = 4'hF; adr = 32'h40;
        dat_w = 32'h99999999; dly = 4'd3;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; cs = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        watch_quiet(6, seen);
        chk("rst in wait no response", {31'd0, seen}, 32'd0);
        chk("rst in wait proto_err", {31'd0, proto_err}, 32'd0);
        xfer(mk(0, 4'hF, 32'h40, 32'h0, 0, 0, 1, 0, 32'h77777777), "post rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/qmem_slave_ram.md
Name: qmem_slave_ram

Overview:
Synthesizable QMEM slave that terminates a QMEM bus in a byte-addressable RAM with programmable wait states and error responses. It sits directly downstream of any QMEM master (CPU port, DMA, bench master model). It gives the bus a realistic endpoint with deterministic ack/err timing for system tests and on-chip scratch memory.

Parameters:
QAW, 32, bus address width (byte address)
QDW, 32, bus data width
QSW, QDW/8, byte-select width
MAW, 10, RAM word-address width (depth = 2**MAW words)
DLYW, 4, width of the wait-state control input
PROTO_STICKY, 1, 1 = proto_err stays set until reset; 0 = proto_err is a one-cycle pulse

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
cs  input  1  chip-select / request
we  input  1  write enable (1 = write, 0 = read)
sel  input  QSW  byte select
adr  input  QAW  byte address
dat_w  input  QDW  write data
dat_r  output  QDW  read data
ack  output  1  transfer acknowledge
err  output  1  transfer error
dly  input  DLYW  wait states inserted before ack/err, sampled at request acceptance
proto_err  output  1  protocol violation flag

Behaviour:
- Reset: ack=0, err=0, dat_r=0, proto_err=0, FSM=IDLE. RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP. Registered outputs only; no combinational path from inputs to ack/err/dat_r.
- IDLE: at a rising edge with cs=1, accept the request.
  - Latch we, sel, adr, dat_w and dly into internal registers.
  - If the latched dly=0, go to RESP; otherwise load the wait counter with dly and go to WAIT.
- WAIT: decrement the counter each cycle; go to RESP when the counter reaches 1.
- Minimum latency: cs sampled at edge N -> ack/err high during cycle N+1. With dly=D, ack/err is high during cycle N+1+D.
- RESP: exactly one of ack or err is high for exactly one cycle. Go to IDLE on the next edge.
  - cs is not re-sampled on that edge, so the master may still hold cs at the completing edge.
  - Maximum throughput: one transfer per 2 cycles.
- Error condition: err replaces ack if either holds:
  - latched adr[QAW-1:MAW+log2(QSW)] is non-zero (out of range), or
  - latched sel is 0.
  - On err: no RAM write, and dat_r holds its previous value.
- Write: the RAM word at adr[MAW+log2(QSW)-1:log2(QSW)] is updated at the edge that enters RESP. Only the bytes with sel[i]=1 are written; the other bytes keep their old value.
- Read: dat_r is loaded at the edge that enters RESP, so it is valid while ack=1. dat_r then holds until the next successful read. All QDW bits are returned regardless of sel.
- Protocol check: cs=0 while in WAIT is a violation.
  - Abort the transfer: no write, no ack, no err. Return to IDLE.
  - Set proto_err (sticky or pulse, per PROTO_STICKY).
- Changes of adr/we/sel/dat_w while in WAIT are ignored, because the latched copies are used.
- rst asserted mid-transfer: abandon the transfer immediately. A pending write is discarded and ack/err are not issued.

Optional Feature:
QMEM_SLAVE_RANDOM_DLY_EN:
- With the macro defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; reset seed 8'hA5) advances every cycle.
  - Its two LSBs, sampled at acceptance, are added to dly, giving 0-3 extra wait states.
  - The addition saturates at 2**DLYW-1.
- Without the macro: no LFSR, and the wait-state count equals dly exactly.

Decomposition:
- Shared package qmem_pkg holds:
  - the FSM state enum (IDLE/WAIT/RESP),
  - the default QAW/QDW widths,
  - the LFSR seed and tap constants.
- Sub-module qmem_ram_be: single-port RAM, 2**MAW x QDW, with a byte-enable write and a registered read. It is instantiated once. Keeping it separate lets the RAM be swapped for a vendor macro.

Test Plan:
- dly=0: write 0x0000_0010, sel=4'hF, data 0xDEADBEEF, then read it back -> ack one cycle after cs each time; dat_r=0xDEADBEEF during the read ack.
- Byte select: write 0x11223344 full word, then write sel=4'b0010 data 0xAABBCCDD to the same address, then read -> dat_r=0x1122CC44.
- dly=5: read -> ack high exactly 6 cycles after cs sampled, err=0; the master holding cs through the completing edge causes no second ack.
- Error cases: address 0x0000_1000 with MAW=10, or sel=0 -> err pulse of one cycle, ack=0, RAM unchanged (a read-back of the prior data matches).
- Abort: dly=4, cs dropped after 2 cycles -> no ack/err, proto_err=1 and held (PROTO_STICKY=1), no write; rst then clears proto_err.
- Reset in WAIT: write with dly=3, rst asserted for 1 cycle mid-wait -> ack never issued, target word unchanged, FSM in IDLE and the next transfer completes normally.
